// File: rtl/game_pkg.sv
// Shared types and constants for the snake game datapath: FSM state encoding,
// object-count limits and the player-index width helper.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int MAX_PLAYERS = 8;
  localparam int MAX_APPLES  = 16;

  // A single player still needs a 1-bit index field so slices never collapse.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/collision_tracker_if.sv
// Pixel-scan flags in, one frame event record out under a valid/ack handshake.
// The slave side is the tracker; the master side is scan pipeline plus game FSM.
interface collision_tracker_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_APPLES  = 4
);
  import game_pkg::*;

  localparam int IDX_W = idx_width(NUM_PLAYERS);

  logic                          frame_start;
  logic                          frame_end;
  logic                          scan_valid;
  logic [NUM_PLAYERS-1:0]        snake_head;
  logic [NUM_PLAYERS-1:0]        snake_body;
  logic                          border;
  logic [NUM_APPLES-1:0]         apple;
  logic                          evt_ack;
  logic                          evt_valid;
  logic [NUM_PLAYERS-1:0]        good_coll;
  logic [NUM_PLAYERS-1:0]        bad_coll;
  logic [NUM_APPLES-1:0]         apple_hit;
  logic [NUM_APPLES*IDX_W-1:0]   apple_owner;
  logic                          overrun;

  modport master (
    output frame_start, frame_end, scan_valid, snake_head, snake_body,
           border, apple, evt_ack,
    input  evt_valid, good_coll, bad_coll, apple_hit, apple_owner, overrun
  );

  modport slave (
    input  frame_start, frame_end, scan_valid, snake_head, snake_body,
           border, apple, evt_ack,
    output evt_valid, good_coll, bad_coll, apple_hit, apple_owner, overrun
  );

endinterface

// File: rtl/collision_tracker_apple_claim.sv
// Per-apple sticky claim: remembers whether the apple was eaten this frame and
// by whom; simultaneous heads resolve to the lowest player index.
module apple_claim #(
  parameter int NUM_PLAYERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   clear,
  input  logic                   sample_en,
  input  logic [NUM_PLAYERS-1:0] head,
  input  logic                   apple,
  output logic                   hit_next,
  output logic [IDX_W-1:0]       owner_next,
  output logic [NUM_PLAYERS-1:0] eat
);

  logic                   hit_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic                   base_hit;
  logic [IDX_W-1:0]       base_owner;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_PLAYERS-1:0] win_onehot;
  logic                   claim;

  always_comb begin
    base_hit   = clear ? 1'b0 : hit_reg;
    base_owner = clear ? '0 : owner_reg;
    win_idx    = '0;
    win_onehot = '0;
    // Descending scan so the lowest set head index is the last one written.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (head[i]) begin
        win_idx       = IDX_W'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
    claim      = sample_en & apple & ~base_hit & (|head);
    eat        = claim ? win_onehot : '0;
    hit_next   = base_hit | claim;
    owner_next = claim ? win_idx : base_owner;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hit_reg   <= 1'b0;
      owner_reg <= '0;
    end else begin
      hit_reg   <= hit_next;
      owner_reg <= owner_next;
    end
  end

endmodule

// File: rtl/collision_tracker.sv
// Frame-based collision tracker: accumulates per-player death/eat state over a
// frame and presents one held event record to the game FSM at end of frame.
module collision_tracker
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_APPLES  = 4
) (
  input logic clk,
  input logic nRst,
  collision_tracker_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PLAYERS);

  state_t state_reg, state_next;
  logic clear, sample_en, latch, ack_take, ovr_set;

  logic [NUM_PLAYERS-1:0]                  bad_acc, good_acc;
  logic [NUM_PLAYERS-1:0]                  bad_next, good_next;
  logic [NUM_PLAYERS-1:0]                  bad_sample, good_sample;
  logic [NUM_APPLES-1:0][NUM_PLAYERS-1:0]  eat_mat;
  logic [NUM_APPLES-1:0]                   hit_next_vec;
  logic [NUM_APPLES*IDX_W-1:0]             owner_next_vec;

  logic                          evt_valid_reg;
  logic [NUM_PLAYERS-1:0]        good_coll_reg, bad_coll_reg;
  logic [NUM_APPLES-1:0]         apple_hit_reg;
  logic [NUM_APPLES*IDX_W-1:0]   apple_owner_reg;
  logic                          overrun_reg;

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    sample_en  = 1'b0;
    latch      = 1'b0;
    ack_take   = 1'b0;
    ovr_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.frame_start) begin
          clear      = 1'b1;
          sample_en  = bus.scan_valid;
          state_next = SCAN;
        end
      end
      SCAN: begin
        sample_en = bus.scan_valid;
        if (bus.frame_end) begin
          // A colliding frame_start is lost; flag it rather than restart.
          latch      = 1'b1;
          ovr_set    = bus.frame_start;
          state_next = REPORT;
        end else if (bus.frame_start) begin
          clear = 1'b1;
        end
      end
      REPORT: begin
        if (bus.evt_ack) begin
          ack_take   = 1'b1;
          state_next = IDLE;
        end else if (bus.frame_start) begin
          ovr_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      localparam logic [NUM_PLAYERS-1:0] SELF = NUM_PLAYERS'(1) << gi;
      assign bad_sample[gi] = bus.snake_head[gi] &
                              (bus.border | (|bus.snake_body) |
                               (|(bus.snake_head & ~SELF)));
    end

    for (gi = 0; gi < NUM_APPLES; gi++) begin : g_apple
      apple_claim #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .IDX_W       (IDX_W)
      ) u_claim (
        .clk        (clk),
        .nRst       (nRst),
        .clear      (clear),
        .sample_en  (sample_en),
        .head       (bus.snake_head),
        .apple      (bus.apple[gi]),
        .hit_next   (hit_next_vec[gi]),
        .owner_next (owner_next_vec[gi*IDX_W +: IDX_W]),
        .eat        (eat_mat[gi])
      );
    end
  endgenerate

  always_comb begin
    good_sample = '0;
    for (int k = 0; k < NUM_APPLES; k++) good_sample = good_sample | eat_mat[k];
    bad_next  = clear ? '0 : bad_acc;
    good_next = clear ? '0 : good_acc;
    if (sample_en) begin
      bad_next  = bad_next | bad_sample;
      good_next = good_next | good_sample;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      bad_acc  <= '0;
      good_acc <= '0;
    end else begin
      bad_acc  <= bad_next;
      good_acc <= good_next;
    end
  end

  // Load from the next-values so the frame_end sample is part of the record.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      evt_valid_reg   <= 1'b0;
      good_coll_reg   <= '0;
      bad_coll_reg    <= '0;
      apple_hit_reg   <= '0;
      apple_owner_reg <= '0;
      overrun_reg     <= 1'b0;
    end else if (latch) begin
      evt_valid_reg   <= 1'b1;
      good_coll_reg   <= good_next & ~bad_next;
      bad_coll_reg    <= bad_next;
      apple_hit_reg   <= hit_next_vec;
      apple_owner_reg <= owner_next_vec;
      overrun_reg     <= ovr_set;
    end else if (ack_take) begin
      evt_valid_reg   <= 1'b0;
      good_coll_reg   <= '0;
      bad_coll_reg    <= '0;
      apple_hit_reg   <= '0;
      apple_owner_reg <= '0;
      overrun_reg     <= 1'b0;
    end else if (ovr_set) begin
      overrun_reg <= 1'b1;
    end
  end

  assign bus.evt_valid   = evt_valid_reg;
  assign bus.good_coll   = good_coll_reg;
  assign bus.bad_coll    = bad_coll_reg;
  assign bus.apple_hit   = apple_hit_reg;
  assign bus.apple_owner = apple_owner_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_collision_tracker.sv
// Directed bench for collision_tracker (2 players, 4 apples): expected event
// records are queued when frame_end is driven and checked when evt_valid rises.
module tb_collision_tracker;

  typedef struct packed {
    logic [1:0] good;
    logic [1:0] bad;
    logic [3:0] hit;
    logic [3:0] owner;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  collision_tracker_if #(.NUM_PLAYERS(2), .NUM_APPLES(4)) bus ();

  collision_tracker #(.NUM_PLAYERS(2), .NUM_APPLES(4)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic fe, input logic sv,
                       input logic [1:0] h, input logic [1:0] b, input logic brd,
                       input logic [3:0] ap, input logic ack);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.scan_valid  = sv;
    bus.snake_head  = h;
    bus.snake_body  = b;
    bus.border      = brd;
    bus.apple       = ap;
    bus.evt_ack     = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_record(input string tag, input exp_t e, input logic check_ovr);
    chk({tag, "_good"},  32'(bus.good_coll),   32'(e.good));
    chk({tag, "_bad"},   32'(bus.bad_coll),    32'(e.bad));
    chk({tag, "_hit"},   32'(bus.apple_hit),   32'(e.hit));
    chk({tag, "_owner"}, 32'(bus.apple_owner), 32'(e.owner));
    if (check_ovr) chk({tag, "_ovr"}, 32'(bus.overrun), 32'(e.ovr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.evt_valid),   32'd0);
    chk({tag, "_good"},  32'(bus.good_coll),   32'd0);
    chk({tag, "_bad"},   32'(bus.bad_coll),    32'd0);
    chk({tag, "_hit"},   32'(bus.apple_hit),   32'd0);
    chk({tag, "_owner"}, 32'(bus.apple_owner), 32'd0);
    chk({tag, "_ovr"},   32'(bus.overrun),     32'd0);
  endtask

  // Drives frame_end (with an optional last sample), then pops and checks.
  task automatic end_frame(input string tag, input logic fs, input logic sv,
                           input logic [1:0] h, input logic [1:0] b, input logic brd,
                           input logic [3:0] ap, input exp_t e);
    int waited;
    sb.push_back(e);
    drive(fs, 1'b1, sv, h, b, brd, ap, 1'b0);
    idle_inputs();
    waited = 0;
    while (bus.evt_valid !== 1'b1 && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk({tag, "_latency"}, 32'(waited), 32'd0);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      cur = sb.pop_front();
      check_record(tag, cur, 1'b1);
      $display("event %s: good=%b bad=%b hit=%b owner=%b ovr=%b", tag,
               bus.good_coll, bus.bad_coll, bus.apple_hit, bus.apple_owner, bus.overrun);
    end
  endtask

  task automatic idle_inputs();
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.scan_valid  = 1'b0;
    bus.snake_head  = '0;
    bus.snake_body  = '0;
    bus.border      = 1'b0;
    bus.apple       = '0;
    bus.evt_ack     = 1'b0;
  endtask

  task automatic ack_and_check(input string tag);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'h0, 1'b1);
    idle_inputs();
    check_zero({tag, "_ack"});
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    nRst = 1'b1;
    idle();

    // Single eat.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b01, 2'b00, 0, 4'b0001, 0);
    end_frame("single_eat", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b01, 2'b00, 4'b0001, 4'b0000, 1'b0});
    ack_and_check("single_eat");

    // Eat then wall death in the same frame.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b10, 2'b00, 0, 4'b0010, 0);
    idle();
    drive(0, 0, 1, 2'b10, 2'b00, 1, 4'h0, 0);
    end_frame("wall_death", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b00, 2'b10, 4'b0010, 4'b0010, 1'b0});

    // Output hold while unacknowledged, inputs churning (no frame_start).
    for (int c = 0; c < 20; c++) begin
      drive(0, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), 0);
      chk("hold_valid", 32'(bus.evt_valid), 32'd1);
      check_record("hold", cur, 1'b1);
    end
    ack_and_check("hold");
    // Ack outside REPORT is ignored and must not disturb the next frame.
    drive(0, 0, 0, 2'b00, 2'b00, 0, 4'h0, 1);

    // Head-on on an apple pixel.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b11, 2'b00, 0, 4'b0100, 0);
    end_frame("head_on", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b00, 2'b11, 4'b0100, 4'b0000, 1'b0});

    // Overrun: frame dropped while the event is pending.
    drive(1, 0, 1, 2'b01, 2'b00, 1, 4'h1, 0);
    chk("overrun_set", 32'(bus.overrun), 32'd1);
    check_record("overrun_hold", cur, 1'b0);
    idle();
    chk("overrun_sticky", 32'(bus.overrun), 32'd1);
    ack_and_check("overrun");

    // Next frame after overrun: frame_start and frame_end samples both count.
    drive(1, 0, 1, 2'b10, 2'b00, 0, 4'b1000, 0);
    end_frame("edge_samples", 0, 1, 2'b01, 2'b00, 1, 4'h0, '{2'b10, 2'b01, 4'b1000, 4'b1000, 1'b0});
    ack_and_check("edge_samples");

    // First eat wins; body collision kills.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b01, 2'b00, 0, 4'b0001, 0);
    drive(0, 0, 1, 2'b10, 2'b00, 0, 4'b0001, 0);
    drive(0, 0, 1, 2'b10, 2'b01, 0, 4'h0, 0);
    end_frame("first_eat", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b01, 2'b10, 4'b0001, 4'b0000, 1'b0});
    ack_and_check("first_eat");

    // Inputs ignored in IDLE; restart in SCAN discards earlier samples.
    drive(0, 0, 1, 2'b01, 2'b00, 1, 4'hF, 0);
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b01, 2'b00, 1, 4'b0001, 0);
    drive(1, 0, 1, 2'b10, 2'b00, 0, 4'b0010, 0);
    end_frame("restart", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b10, 2'b00, 4'b0010, 4'b0010, 1'b0});
    ack_and_check("restart");

    // frame_start and frame_end together in SCAN: report, flag overrun.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b01, 2'b10, 0, 4'h0, 0);
    end_frame("start_end", 1, 1, 2'b10, 2'b00, 0, 4'b0100, '{2'b10, 2'b01, 4'b0100, 4'b0100, 1'b1});
    ack_and_check("start_end");

    // Reset mid-SCAN, then a hit-free frame.
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b01, 2'b00, 0, 4'b0001, 0);
    #2 nRst = 1'b0;
    #1;
    check_zero("rst_scan");
    @(posedge clk);
    #1 nRst = 1'b1;
    drive(0, 1, 1, 2'b01, 2'b00, 1, 4'h1, 0);
    chk("rst_no_partial", 32'(bus.evt_valid), 32'd0);
    drive(1, 0, 0, 2'b00, 2'b00, 0, 4'h0, 0);
    drive(0, 0, 1, 2'b00, 2'b11, 1, 4'hF, 0);
    end_frame("post_reset", 0, 0, 2'b00, 2'b00, 0, 4'h0, '{2'b00, 2'b00, 4'b0000, 4'b0000, 1'b0});

    // Reset while the event is pending clears it asynchronously.
    #2 nRst = 1'b0;
    #1;
    check_zero("rst_report");
    @(posedge clk);
    #1 nRst = 1'b1;
    idle();
    check_zero("rst_report_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
